// File: rtl/piece_bag_gen.sv
// piece_bag_gen: seedable Galois LFSR feeding a bag shuffler. Each bag issues
// every piece ID exactly once, in pseudo-random order, over valid/ready.
//
// Handshake: piece_valid/piece_id are registered and held stable while
// piece_ready is low; a transfer happens on a clock edge where both
// piece_valid and piece_ready are high. seed_load overrides everything except
// reset and discards any presented piece, even on a would-be transfer edge.
module piece_bag_gen #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [WIDTH-1:0] SEED       = 16'hACE1,
  parameter int               NUM_PIECES = 7,
  parameter int               MAX_TRIES  = 15,
  localparam int              IDW        = $clog2(NUM_PIECES),
  localparam int              CW         = $clog2(NUM_PIECES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             piece_ready,
  output logic             piece_valid,
  output logic [IDW-1:0]   piece_id,
  output logic [CW-1:0]    bag_remaining,
  output logic [WIDTH-1:0] lfsr_o
);

  localparam int           TW     = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam int           CAND_N = 1 << IDW;
  localparam logic [IDW:0] NP_W   = (IDW + 1)'(NUM_PIECES);
  localparam logic [CW-1:0] NP_C  = CW'(NUM_PIECES);

  typedef enum logic {ST_DRAW, ST_PRESENT} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        lfsr_q, lfsr_d;
  logic [NUM_PIECES-1:0]   used_q, used_d;
  logic [TW-1:0]           tries_q, tries_d;
  logic                    valid_q, valid_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [CW-1:0]           rem_q, rem_d;

  logic [WIDTH-1:0]        lfsr_step;
  logic [IDW-1:0]          cand;
  logic [CAND_N-1:0]       used_pad;
  logic                    cand_ok;
  logic                    fallback;
  logic [IDW-1:0]          low_idx;
  logic [IDW-1:0]          pick;

  // Candidate evaluation: raw LFSR draw, plus lowest-unused fallback pick.
  always_comb begin
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    cand      = lfsr_q[IDW-1:0];
    // Pad the mask to the full candidate range so out-of-range draws read 0.
    used_pad  = CAND_N'(used_q);
    cand_ok   = ({1'b0, cand} < NP_W) && !used_pad[cand];
    fallback  = (tries_q == TW'(MAX_TRIES));
    low_idx   = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!used_q[i]) low_idx = IDW'(i);
    end
    pick = fallback ? low_idx : cand;
  end

  // Next-state logic for the LFSR, bag mask, try counter and draw/present FSM.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_step;
    used_d  = used_q;
    tries_d = tries_q;
    valid_d = valid_q;
    id_d    = id_q;
    rem_d   = rem_q;
    if (seed_load) begin
      lfsr_d  = (seed_in == '0) ? SEED : seed_in;
      used_d  = '0;
      tries_d = '0;
      valid_d = 1'b0;
      rem_d   = NP_C;
      state_d = ST_DRAW;
    end else begin
      case (state_q)
        ST_DRAW: begin
          if (fallback || cand_ok) begin
            id_d    = pick;
            used_d  = used_q | (NUM_PIECES'(1) << pick);
            valid_d = 1'b1;
            rem_d   = rem_q - CW'(1);
            tries_d = '0;
            state_d = ST_PRESENT;
          end else begin
            tries_d = tries_q + TW'(1);
          end
        end
        ST_PRESENT: begin
          if (piece_ready) begin
            valid_d = 1'b0;
            state_d = ST_DRAW;
            // Last piece of the bag just left: start a fresh bag.
            if (&used_q) begin
              used_d = '0;
              rem_d  = NP_C;
            end
          end
        end
      endcase
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_DRAW;
      lfsr_q  <= SEED;
      used_q  <= '0;
      tries_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      rem_q   <= NP_C;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      used_q  <= used_d;
      tries_q <= tries_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
    end
  end

  assign piece_valid   = valid_q;
  assign piece_id      = id_q;
  assign bag_remaining = rem_q;
  assign lfsr_o        = lfsr_q;

endmodule

// File: tb/tb_piece_bag_gen.sv
// Bench for piece_bag_gen: a 7-piece default instance and a 3-piece,
// 2-try instance that exercises the fallback pick. Both share clock, reset
// and seed controls; each has its own ready line and behavioural model.
module tb_piece_bag_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        ready_a, ready_b;

  logic        valid_a, valid_b;
  logic [2:0]  id_a, rem_a;
  logic [1:0]  id_b, rem_b;
  logic [15:0] lfsr_a, lfsr_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // Clock
  always #5 clk = ~clk;

  piece_bag_gen u_dut_a (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .piece_ready(ready_a), .piece_valid(valid_a), .piece_id(id_a),
    .bag_remaining(rem_a), .lfsr_o(lfsr_a)
  );

  piece_bag_gen #(.NUM_PIECES(3), .MAX_TRIES(2)) u_dut_b (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .piece_ready(ready_b), .piece_valid(valid_b), .piece_id(id_b),
    .bag_remaining(rem_b), .lfsr_o(lfsr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int unsigned lfsr;
    int unsigned used;   // bit i set = piece i already drawn this bag
    int          tries;
    bit          valid;
    int          id;
  } mdl_t;

  mdl_t ma, mb;
  int   fb_cnt_b = 0;
  int   hs_cnt[2];
  int   log_q[2][$];

  bit        snap_valid_a, snap_valid_b;
  int        snap_id_a, snap_id_b;
  bit        wait_b = 0;
  int        lat_b  = 0;

  function automatic void model_reset(output mdl_t m);
    m.lfsr = 32'hACE1; m.used = 0; m.tries = 0; m.valid = 0; m.id = 0;
  endfunction

  task automatic model_step(inout mdl_t m, input int n, input int max_tries,
                            input int unsigned id_mask, input bit ld,
                            input int unsigned sin, input bit rdy, output bit fb);
    int unsigned nxt;
    int c;
    fb  = 0;
    nxt = (m.lfsr % 2 == 1) ? ((m.lfsr / 2) ^ 32'hB400) : (m.lfsr / 2);
    if (ld) begin
      m.lfsr  = (sin == 0) ? 32'hACE1 : sin;
      m.used  = 0;
      m.tries = 0;
      m.valid = 0;
    end else begin
      if (!m.valid) begin
        c = int'(m.lfsr & id_mask);
        if (m.tries == max_tries) begin
          fb = 1;
          c  = -1;
          for (int i = 0; i < n; i++)
            if (c < 0 && ((m.used >> i) & 1) == 0) c = i;
        end
        if (fb || (c < n && ((m.used >> c) & 1) == 0)) begin
          m.id    = c;
          m.used  = m.used | (1 << c);
          m.valid = 1;
          m.tries = 0;
        end else begin
          m.tries++;
        end
      end else if (rdy) begin
        m.valid = 0;
        if (m.used == (1 << n) - 1) m.used = 0;
      end
      m.lfsr = nxt;
    end
  endtask

  function automatic bit is_perm(input int k, input int n);
    int cnt;
    is_perm = (log_q[k].size() == n);
    for (int v = 0; v < n; v++) begin
      cnt = 0;
      foreach (log_q[k][j]) if (log_q[k][j] == v) cnt++;
      if (cnt != 1) is_perm = 0;
    end
  endfunction

  // Record accepted DUT pieces (sampled before the edge) and check each bag.
  task automatic log_dut(input int k, input int n, input bit v, input int id, input bit r);
    if (seed_load) log_q[k].delete();
    else if (v && r) begin
      log_q[k].push_back(id);
      hs_cnt[k]++;
      if (log_q[k].size() == n) begin
        check(k == 0 ? "bag_perm_a" : "bag_perm_b", 32'(is_perm(k, n)), 32'd1);
        log_q[k].delete();
      end
    end
  endtask

  // Model advance on every edge; asynchronous reset mirrors the DUT.
  always @(posedge clk or posedge reset) begin
    bit fb;
    if (reset) begin
      model_reset(ma);
      model_reset(mb);
      log_q[0].delete();
      log_q[1].delete();
    end else begin
      log_dut(0, 7, snap_valid_a, snap_id_a, ready_a);
      log_dut(1, 3, snap_valid_b, snap_id_b, ready_b);
      model_step(ma, 7, 15, 32'd7, seed_load, 32'(seed_in), ready_a, fb);
      model_step(mb, 3, 2, 32'd3, seed_load, 32'(seed_in), ready_b, fb);
      if (fb) fb_cnt_b++;
    end
  end

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    check("a_lfsr",  32'(lfsr_a),  ma.lfsr);
    check("a_valid", 32'(valid_a), 32'(ma.valid));
    check("a_id",    32'(id_a),    32'(ma.id));
    check("a_rem",   32'(rem_a),   32'(7 - $countones(ma.used)));
    check("b_lfsr",  32'(lfsr_b),  mb.lfsr);
    check("b_valid", 32'(valid_b), 32'(mb.valid));
    check("b_id",    32'(id_b),    32'(mb.id));
    check("b_rem",   32'(rem_b),   32'(3 - $countones(mb.used)));
    // Handshake-to-next-valid latency on the fallback instance.
    if (reset || seed_load) wait_b = 0;
    else begin
      if (wait_b) begin
        lat_b++;
        if (valid_b) begin
          check("b_latency_ok", 32'(lat_b <= 4), 32'd1);
          wait_b = 0;
        end else if (lat_b > 4) begin
          check("b_latency_timeout", 32'(lat_b), 32'd4);
          wait_b = 0;
        end
      end
      if (snap_valid_b && ready_b) begin
        wait_b = 1;
        lat_b  = 0;
      end
    end
    snap_valid_a = valid_a; snap_id_a = int'(id_a);
    snap_valid_b = valid_b; snap_id_b = int'(id_b);
  end

  // ---------------- stimulus ----------------
  initial begin
    int          base, cyc, k;
    bit          seen7;
    logic [15:0] s;
    int          held;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    reset = 1'b1; seed_load = 1'b0; seed_in = '0; ready_a = 1'b0; ready_b = 1'b0;

    // Reset held two cycles
    repeat (2) begin
      @(negedge clk);
      check("rst_lfsr",  32'(lfsr_a),  32'hACE1);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_id",    32'(id_a),    32'd0);
      check("rst_rem",   32'(rem_a),   32'd7);
    end
    #1 reset = 1'b0;

    @(negedge clk);
    check("step1_lfsr",  32'(lfsr_a),  32'hE270);
    check("first_valid", 32'(valid_a), 32'd1);
    check("first_id",    32'(id_a),    32'd1);
    check("first_rem",   32'(rem_a),   32'd6);
    @(negedge clk);
    check("step2_lfsr",  32'(lfsr_a),  32'h7138);

    // Full bag: two bags with ready held high
    #1 ready_a = 1'b1; ready_b = 1'b1;
    base = hs_cnt[0]; cyc = 0; seen7 = 0;
    while (hs_cnt[0] - base < 14 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (!seen7 && hs_cnt[0] - base == 7) begin
        seen7 = 1;
        check("bag_refill_rem",   32'(rem_a),   32'd7);
        check("bag_refill_valid", 32'(valid_a), 32'd0);
      end
    end
    check("full_bag_done", 32'(hs_cnt[0] - base), 32'd14);
    #1 ready_a = 1'b0; ready_b = 1'b0;

    // Backpressure: hold a presented piece for 20 cycles
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ma.valid && cyc < 20);
    check("bp_got_valid", 32'(ma.valid), 32'd1);
    held = ma.id;
    repeat (20) begin
      @(negedge clk);
      check("bp_id_stable",    32'(id_a),    32'(held));
      check("bp_valid_stable", 32'(valid_a), 32'd1);
    end

    // Zero seed substitutes SEED
    #1 seed_load = 1'b1; seed_in = '0;
    @(negedge clk);
    check("zseed_lfsr",  32'(lfsr_a),  32'hACE1);
    check("zseed_valid", 32'(valid_a), 32'd0);
    check("zseed_rem",   32'(rem_a),   32'd7);
    #1 seed_load = 1'b0;

    // seed_load coinciding with a would-be handshake
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!ma.valid && cyc < 20);
    check("sh_got_valid", 32'(ma.valid), 32'd1);
    k = $urandom_range(0, 6);
    s = 16'(($urandom_range(1, 8191) << 3) | k);
    #1 seed_load = 1'b1; seed_in = s; ready_a = 1'b1; ready_b = 1'b1;
    @(negedge clk);
    check("sh_valid", 32'(valid_a), 32'd0);
    check("sh_rem",   32'(rem_a),   32'd7);
    check("sh_lfsr",  32'(lfsr_a),  32'(s));
    #1 seed_load = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    @(negedge clk);
    check("sh_next_valid", 32'(valid_a), 32'd1);
    check("sh_next_id",    32'(id_a),    32'(k));
    check("sh_next_rem",   32'(rem_a),   32'd6);

    // Randomized traffic, with one asynchronous mid-cycle reset
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_lfsr",  32'(lfsr_a),  32'hACE1);
        check("async_rst_valid", 32'(valid_a), 32'd0);
        check("async_rst_rem",   32'(rem_a),   32'd7);
        check("async_rst_rem_b", 32'(rem_b),   32'd3);
        @(negedge clk);
        #1 reset = 1'b0;
      end
      @(negedge clk);
      #1;
      ready_a   = ($urandom_range(0, 9) < 7);
      ready_b   = ($urandom_range(0, 9) < 6);
      seed_load = ($urandom_range(0, 199) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    end
    #1 seed_load = 1'b0;
    @(negedge clk);

    check("fallback_seen", 32'(fb_cnt_b > 0), 32'd1);
    check("bags_a_seen",   32'(hs_cnt[0] > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
